// File: rtl/memory_dual_port_be.sv
// True dual-port RAM with per-byte write enables, configurable read latency,
// selectable same-port read-during-write result and a post-reset clear engine.
module memory_dual_port_be #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DWIDTH-1:0] CLEAR_VALUE = '0,
    parameter CONTENT = "",
    localparam int NBYTE = DWIDTH / 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    input  logic [AWIDTH-1:0] address_a,
    input  logic [DWIDTH-1:0] data_a,
    input  logic [NBYTE-1:0]  byteena_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DWIDTH-1:0] q_a,
    output logic              q_valid_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic [DWIDTH-1:0] data_b,
    input  logic [NBYTE-1:0]  byteena_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DWIDTH-1:0] q_b,
    output logic              q_valid_b
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic CLEAR_EN = (CLEAR_ON_RESET != 0);

    typedef enum logic [1:0] {IDLE, CLEAR, READY} clear_state_t;

    clear_state_t      state_reg, state_next;
    logic [AWIDTH-1:0] clear_count_reg, clear_count_next;

    // Index 0 is port A, index 1 is port B.
    logic [1:0][AWIDTH-1:0] port_addr;
    logic [1:0][DWIDTH-1:0] port_data;
    logic [1:0][NBYTE-1:0]  port_be;
    logic [1:0]             port_we;
    logic [1:0]             port_re;
    logic [1:0][DWIDTH-1:0] stage1_word;
    logic [1:0][DWIDTH-1:0] port_q;
    logic [1:0]             port_qv;

    assign port_addr = {address_b, address_a};
    assign port_data = {data_b, data_a};
    assign port_be   = {byteena_b, byteena_a};
    assign port_we   = {wren_b, wren_a} & {2{~busy}};
    assign port_re   = {rden_b, rden_a} & {2{~busy}};

    assign q_a       = port_q[0];
    assign q_b       = port_q[1];
    assign q_valid_a = port_qv[0];
    assign q_valid_b = port_qv[1];

    // IDLE is only held during reset; it clears word 0 on the first edge
    // after release so the whole sweep takes exactly DEPTH cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= CLEAR_EN ? IDLE : READY;
            clear_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            clear_count_reg <= clear_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        clear_count_next = clear_count_reg;
        case (state_reg)
            IDLE, CLEAR: begin
                clear_count_next = clear_count_reg + 1'b1;
                if (clear_count_reg == AWIDTH'(DEPTH - 1)) begin
                    state_next = READY;
                end else begin
                    state_next = CLEAR;
                end
            end
            READY:   state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    assign busy = CLEAR_EN && (state_reg != READY);

    generate
        for (genvar gi = 0; gi < NBYTE; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [1:0] lane_we;

            assign lane_we = port_we & {port_be[1][gi], port_be[0][gi]};

            // Port A is written last so it owns any lane both ports enable.
            always_ff @(posedge clock) begin
                if (busy) begin
                    lane_mem[clear_count_reg] <= CLEAR_VALUE[8*gi +: 8];
                end
                if (lane_we[1]) begin
                    lane_mem[port_addr[1]] <= port_data[1][8*gi +: 8];
                end
                if (lane_we[0]) begin
                    lane_mem[port_addr[0]] <= port_data[0][8*gi +: 8];
                end
            end

            for (genvar gp = 0; gp < 2; gp++) begin : g_rd
                logic [7:0] rd_reg;

                // New-data mode forwards only this port's own enabled lanes;
                // the other port's write is never visible in the same cycle.
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        rd_reg <= '0;
                    end else if (port_re[gp]) begin
                        if ((RDW_MODE != 0) && lane_we[gp]) begin
                            rd_reg <= port_data[gp][8*gi +: 8];
                        end else begin
                            rd_reg <= lane_mem[port_addr[gp]];
                        end
                    end
                end

                assign stage1_word[gp][8*gi +: 8] = rd_reg;
            end
        end

        for (genvar gp = 0; gp < 2; gp++) begin : g_port
            logic valid1_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid1_reg <= 1'b0;
                end else begin
                    valid1_reg <= port_re[gp];
                end
            end

            if (RD_LATENCY == 2) begin : g_lat2
                logic [DWIDTH-1:0] q2_reg;
                logic              valid2_reg;

                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        q2_reg     <= '0;
                        valid2_reg <= 1'b0;
                    end else begin
                        valid2_reg <= valid1_reg;
                        if (valid1_reg) begin
                            q2_reg <= stage1_word[gp];
                        end
                    end
                end

                assign port_q[gp]  = q2_reg;
                assign port_qv[gp] = valid2_reg;
            end else begin : g_lat1
                assign port_q[gp]  = stage1_word[gp];
                assign port_qv[gp] = valid1_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_memory_dual_port_be.sv
// Directed bench: two instances share stimulus (old-data/latency-1 and
// new-data/latency-2) and are checked against hand-computed values.
module tb_memory_dual_port_be;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = 4;
    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address_a = '0, address_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic [NB-1:0] byteena_a = '0, byteena_b = '0;
    logic          wren_a = 1'b0, rden_a = 1'b0, wren_b = 1'b0, rden_b = 1'b0;

    logic          busy0, busy1;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
    logic          qv_a0, qv_b0, qv_a1, qv_b1;

    memory_dual_port_be #(
        .DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV), .CONTENT("")
    ) u_dut0 (
        .clock(clock), .reset(reset), .busy(busy0),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
        .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a0), .q_valid_a(qv_a0),
        .address_b(address_b), .data_b(data_b), .byteena_b(byteena_b),
        .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b0), .q_valid_b(qv_b0)
    );

    memory_dual_port_be #(
        .DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV), .CONTENT("")
    ) u_dut1 (
        .clock(clock), .reset(reset), .busy(busy1),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
        .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a1), .q_valid_a(qv_a1),
        .address_b(address_b), .data_b(data_b), .byteena_b(byteena_b),
        .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b1), .q_valid_b(qv_b1)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        logic [3:0]  aa;
        logic [31:0] da;
        logic [3:0]  ba;
        logic        wa;
        logic        ra;
        logic [3:0]  ab;
        logic [31:0] db;
        logic [3:0]  bb;
        logic        wb;
        logic        rb;
        logic [31:0] qa0;
        logic [31:0] qb0;
        logic [31:0] qa1;
        logic [31:0] qb1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        address_a = '0; data_a = '0; byteena_a = '0; wren_a = 1'b0; rden_a = 1'b0;
        address_b = '0; data_b = '0; byteena_b = '0; wren_b = 1'b0; rden_b = 1'b0;
    endtask

    function automatic vec_t mk(input string n,
                                input logic [3:0] aa, input logic [31:0] da, input logic [3:0] ba,
                                input logic wa, input logic ra,
                                input logic [3:0] ab, input logic [31:0] db, input logic [3:0] bb,
                                input logic wb, input logic rb,
                                input logic [31:0] qa0, input logic [31:0] qb0,
                                input logic [31:0] qa1, input logic [31:0] qb1);
        vec_t v;
        v.name = n; v.aa = aa; v.da = da; v.ba = ba; v.wa = wa; v.ra = ra;
        v.ab = ab; v.db = db; v.bb = bb; v.wb = wb; v.rb = rb;
        v.qa0 = qa0; v.qb0 = qb0; v.qa1 = qa1; v.qb1 = qb1;
        return v;
    endfunction

    // One-cycle transaction; latency-1 results checked after the first edge,
    // latency-2 results after the second.
    task automatic apply(input vec_t v);
        address_a = v.aa; data_a = v.da; byteena_a = v.ba; wren_a = v.wa; rden_a = v.ra;
        address_b = v.ab; data_b = v.db; byteena_b = v.bb; wren_b = v.wb; rden_b = v.rb;
        tick;
        idle_inputs;
        check({v.name, ".qv_a0"}, 32'(qv_a0), 32'(v.ra));
        check({v.name, ".qv_b0"}, 32'(qv_b0), 32'(v.rb));
        if (v.ra) check({v.name, ".q_a0"}, q_a0, v.qa0);
        if (v.rb) check({v.name, ".q_b0"}, q_b0, v.qb0);
        check({v.name, ".qv_a1_early"}, 32'(qv_a1), 32'(0));
        check({v.name, ".qv_b1_early"}, 32'(qv_b1), 32'(0));
        tick;
        check({v.name, ".qv_a1"}, 32'(qv_a1), 32'(v.ra));
        check({v.name, ".qv_b1"}, 32'(qv_b1), 32'(v.rb));
        if (v.ra) check({v.name, ".q_a1"}, q_a1, v.qa1);
        if (v.rb) check({v.name, ".q_b1"}, q_b1, v.qb1);
        check({v.name, ".qv_a0_pulse"}, 32'(qv_a0), 32'(0));
        $display("txn %s: q_a0=%h q_b0=%h q_a1=%h q_b1=%h", v.name, q_a0, q_b0, q_a1, q_b1);
    endtask

    // Counts the busy window after reset release; optionally hammers both
    // ports, which must be ignored.
    task automatic clear_window(input string name, input logic poke);
        for (int n = 1; n <= 16; n++) begin
            if (poke) begin
                address_a = 4'(n); data_a = '0; byteena_a = 4'hF; wren_a = 1'b1; rden_a = 1'b1;
                address_b = 4'(n + 3); data_b = 32'h12345678; byteena_b = 4'hF;
                wren_b = 1'b1; rden_b = 1'b1;
            end
            tick;
            check($sformatf("%s.busy0[%0d]", name, n), 32'(busy0), 32'(n < 16));
            check($sformatf("%s.busy1[%0d]", name, n), 32'(busy1), 32'(n < 16));
            check($sformatf("%s.qv_busy[%0d]", name, n),
                  {28'd0, qv_a0, qv_b0, qv_a1, qv_b1}, 32'd0);
            $display("txn %s cycle %0d: busy0=%0b busy1=%0b", name, n, busy0, busy1);
        end
        idle_inputs;
    endtask

    task automatic read_all_clear(input string name);
        for (int i = 0; i < 16; i++) begin
            apply(mk($sformatf("%s%0d", name, i), 4'(i), '0, '0, 1'b0, 1'b1,
                     4'(15 - i), '0, '0, 1'b0, 1'b1, CV, CV, CV, CV));
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk("be_wr",    4'd3, 32'h11223344, 4'b0101, 1, 0, 4'd0, '0, '0, 0, 0, '0, '0, '0, '0));
        vecs.push_back(mk("be_rd_a",  4'd3, '0, '0, 0, 1, 4'd0, '0, '0, 0, 0,
                          32'hA522A544, '0, 32'hA522A544, '0));
        vecs.push_back(mk("be_rd_b",  4'd0, '0, '0, 0, 0, 4'd3, '0, '0, 0, 1,
                          '0, 32'hA522A544, '0, 32'hA522A544));
        vecs.push_back(mk("zero",     4'd5, '0, 4'hF, 1, 0, 4'd6, '0, 4'hF, 1, 0, '0, '0, '0, '0));
        vecs.push_back(mk("rdw",      4'd5, 32'hDEADBEEF, 4'hF, 1, 1, 4'd5, '0, '0, 0, 1,
                          32'h0, 32'h0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk("rdw_after", 4'd5, '0, '0, 0, 1, 4'd6, '0, '0, 0, 1,
                          32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk("collide",  4'd6, 32'hAAAAAAAA, 4'b0011, 1, 0, 4'd6, 32'hBBBBBBBB, 4'b0110, 1, 0,
                          '0, '0, '0, '0));
        vecs.push_back(mk("coll_rd",  4'd6, '0, '0, 0, 1, 4'd3, '0, '0, 0, 1,
                          32'h00BBAAAA, 32'hA522A544, 32'h00BBAAAA, 32'hA522A544));
        vecs.push_back(mk("be0_rdw",  4'd0, '0, '0, 0, 0, 4'd7, 32'h12345678, 4'b0000, 1, 1,
                          '0, CV, '0, CV));
        vecs.push_back(mk("be0_rd",   4'd0, '0, '0, 0, 0, 4'd7, '0, '0, 0, 1, '0, CV, '0, CV));
        vecs.push_back(mk("lane3_rdw", 4'd0, '0, '0, 0, 0, 4'd8, 32'hCAFEF00D, 4'b1000, 1, 1,
                          '0, CV, '0, 32'hCAA5A5A5));
        vecs.push_back(mk("lane3_rd", 4'd8, '0, '0, 0, 1, 4'd0, '0, '0, 0, 0,
                          32'hCAA5A5A5, '0, 32'hCAA5A5A5, '0));
        vecs.push_back(mk("xport",    4'd9, '0, '0, 0, 1, 4'd9, 32'h0, 4'hF, 1, 0, CV, '0, CV, '0));
        vecs.push_back(mk("xport_rd", 4'd9, '0, '0, 0, 1, 4'd0, '0, '0, 0, 0, 32'h0, '0, 32'h0, '0));

        // Reset state and initial clear.
        tick;
        tick;
        check("rst.busy0", 32'(busy0), 32'd1);
        check("rst.busy1", 32'(busy1), 32'd1);
        check("rst.q", q_a0 | q_b0 | q_a1 | q_b1, 32'd0);
        check("rst.qv", {28'd0, qv_a0, qv_b0, qv_a1, qv_b1}, 32'd0);
        reset = 1'b0;
        clear_window("clr", 1'b0);
        read_all_clear("clr_rd");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Back-to-back reads of addresses 0..3 holding 0..3.
        for (int i = 0; i < 4; i++) begin
            apply(mk($sformatf("pl_wr%0d", i), 4'(i), 32'(i), 4'hF, 1, 0, 4'd0, '0, '0, 0, 0,
                     '0, '0, '0, '0));
        end
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) begin
                address_a = 4'(k - 1);
                rden_a = 1'b1;
            end else begin
                idle_inputs;
            end
            tick;
            check($sformatf("pl.qv_a0[%0d]", k), 32'(qv_a0), 32'(k <= 4));
            check($sformatf("pl.q_a0[%0d]", k), q_a0, (k <= 4) ? 32'(k - 1) : 32'd3);
            check($sformatf("pl.qv_a1[%0d]", k), 32'(qv_a1), 32'(k >= 2 && k <= 5));
            if (k >= 2) check($sformatf("pl.q_a1[%0d]", k), q_a1, (k <= 5) ? 32'(k - 2) : 32'd3);
            $display("txn pl cycle %0d: qv_a0=%0b q_a0=%h qv_a1=%0b q_a1=%h", k, qv_a0, q_a0, qv_a1, q_a1);
        end
        idle_inputs;

        // Reset partway through a clear sweep (counter at 7).
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        reset = 1'b1;
        #1;
        check("mid.busy", {30'd0, busy0, busy1}, 32'd3);
        check("mid.q_flush", q_a0 | q_a1, 32'd0);
        tick;
        tick;
        reset = 1'b0;
        clear_window("mid", 1'b1);
        read_all_clear("mid_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
